uart_word_receiver: RTL and testbench

Upstream stage of the UART-to-SPI path: receives 8N1 UART bytes on `rx`, packs each group of `BYTES_PER_WORD` bytes into one word, and presents it to the word memory as a one-cycle write strobe with an auto-incrementing write address. The SPI transmitter later reads these words back out of that memory. Storage is gated by the existing active-low `din_en` control. Framing errors are flagged and the affected word is discarded.

---
 rtl/uart_word_receiver.sv | 138 +++++++++++++
 tb/tb_uart_word_receiver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_receiver.sv
// 8N1 UART receiver that packs BYTES_PER_WORD bytes (first byte in the MSBs) into a word
// and issues a one-cycle write strobe with an auto-incrementing, wrapping address.
module uart_word_receiver #(
    parameter int CLKS_PER_BIT   = 400,
    parameter int BYTES_PER_WORD = 3,
    parameter int ADDR_W         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic                        din_en,
    output logic [8*BYTES_PER_WORD-1:0] word_data,
    output logic                        word_valid,
    output logic [ADDR_W-1:0]           word_addr,
    output logic                        frame_err,
    output logic                        busy
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(BYTES_PER_WORD + 1);
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t             state;
    logic [1:0]         sync;
    logic               rx_s;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  word_buf;
    logic [WORD_W-1:0]  word_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];

    // Partial word with the just-completed byte dropped into its slot.
    always_comb begin
        word_next = word_buf;
        word_next[8*(BYTES_PER_WORD-1-int'(idx)) +: 8] = shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            idx        <= '0;
            word_buf   <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_addr  <= '0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (word_valid) word_addr <= word_addr + 1'b1;

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        cnt     <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            if (!din_en) begin
                                word_buf <= word_next;
                                if (idx == IDX_LAST) begin
                                    word_data  <= word_next;
                                    word_valid <= 1'b1;
                                    idx        <= '0;
                                end else begin
                                    idx <= idx + 1'b1;
                                end
                            end else begin
                                idx <= '0;
                            end
                        end else begin
                            // Bad stop bit: drop byte and partial word, wait out the low line.
                            frame_err <= 1'b1;
                            idx       <= '0;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_receiver.sv
// Self-checking bench: a 400 clk/bit instance for the basic word, and a fast
// 16 clk/bit, 2-bit-address instance checked against a byte-level reference model.
module tb_uart_word_receiver;
    localparam int CPB   = 16;
    localparam int CPB_A = 400;
    localparam int STROBE_LAT = 3 + CPB/2 + 9*CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rx_a = 1'b1, din_en_a = 1'b0;
    logic [23:0] word_data_a;
    logic        word_valid_a, frame_err_a, busy_a;
    logic [3:0]  word_addr_a;

    logic        rx_b = 1'b1, din_en_b = 1'b0;
    logic [23:0] word_data_b;
    logic        word_valid_b, frame_err_b, busy_b;
    logic [1:0]  word_addr_b;

    uart_word_receiver #(.CLKS_PER_BIT(CPB_A), .BYTES_PER_WORD(3), .ADDR_W(4)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .din_en(din_en_a),
        .word_data(word_data_a), .word_valid(word_valid_a), .word_addr(word_addr_a),
        .frame_err(frame_err_a), .busy(busy_a)
    );

    uart_word_receiver #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(3), .ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .din_en(din_en_b),
        .word_data(word_data_b), .word_valid(word_valid_b), .word_addr(word_addr_b),
        .frame_err(frame_err_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-level reference model: words complete every third accepted byte while enabled.
    typedef struct { logic [23:0] data; int addr; } exp_t;
    exp_t        exp_q[$];
    logic [23:0] m_buf = '0;
    int          m_idx = 0, m_addr = 0, exp_ferr = 0, exp_strobes = 0;

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input logic en_n);
        exp_t e;
        if (!stop_ok) begin
            exp_ferr++;
            m_idx = 0;
        end else if (en_n) begin
            m_idx = 0;
        end else begin
            m_buf = {m_buf[15:0], b};
            m_idx++;
            if (m_idx == 3) begin
                e.data = m_buf;
                e.addr = m_addr;
                exp_q.push_back(e);
                exp_strobes++;
                m_addr = (m_addr + 1) % 4;
                m_idx  = 0;
            end
        end
    endfunction

    // Monitor for the fast instance.
    logic [23:0] last_word = '0;
    int last_strobe_cyc = 0, last_ferr_cyc = 0, obs_ferr = 0, obs_strobes = 0;
    logic prev_wv = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid_b) begin
                exp_t e;
                obs_strobes++;
                last_word       = word_data_b;
                last_strobe_cyc = cyc;
                check("strobe_width", 32'(prev_wv), 0);
                check("valid_ferr_excl", 32'(frame_err_b), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 32'(word_data_b), 32'(e.data));
                    check("word_addr", 32'(word_addr_b), 32'(e.addr));
                end
            end
            if (frame_err_b) begin
                obs_ferr++;
                last_ferr_cyc = cyc;
            end
            prev_wv = word_valid_b;
        end else begin
            prev_wv = 1'b0;
        end
    end

    // Monitor for the 400 clk/bit instance.
    int n_strobe_a = 0, n_ferr_a = 0;
    logic [23:0] a_word = '0;
    logic [3:0]  a_addr = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid_a) begin
                n_strobe_a++;
                a_word = word_data_a;
                a_addr = word_addr_a;
            end
            if (frame_err_a) n_ferr_a++;
        end
    end

    int t_fall = 0;

    // Called on a falling edge; stop bit stays high with gap=0 so frames abut.
    task automatic send_b(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        model_frame(b, stop_ok, din_en_b);
        rx_b   = 1'b0;
        t_fall = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_b = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_b = stop_ok;
        repeat (CPB) @(negedge clk);
        if (!stop_ok) begin
            repeat (3*CPB) @(negedge clk);
            rx_b = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx_b = 1'b1;
        repeat (gap_bits*CPB) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] b);
        rx_a = 1'b0;
        repeat (CPB_A) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a = b[i];
            repeat (CPB_A) @(negedge clk);
        end
        rx_a = 1'b1;
        repeat (CPB_A) @(negedge clk);
    endtask

    typedef struct { logic [7:0] b0, b1, b2; logic [23:0] exp; } vec_t;
    vec_t tbl[5];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes0, addr0;
        tbl[0] = '{8'h55, 8'hAA, 8'h12, 24'h55AA12};
        tbl[1] = '{8'hDE, 8'hAD, 8'hBE, 24'hDEADBE};
        tbl[2] = '{8'h7F, 8'h80, 8'h01, 24'h7F8001};
        tbl[3] = '{8'h55, 8'hAA, 8'h12, 24'h55AA12};
        tbl[4] = '{8'hFF, 8'h00, 8'h80, 24'hFF0080};

        repeat (3) @(negedge clk);
        check("rst_word_data", 32'(word_data_b), 0);
        check("rst_word_valid", 32'(word_valid_b), 0);
        check("rst_word_addr", 32'(word_addr_b), 0);
        check("rst_frame_err", 32'(frame_err_b), 0);
        check("rst_busy", 32'(busy_b), 0);
        check("rst_a_word_data", 32'(word_data_a), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic word at 400 clocks per bit.
        send_a(8'h55); send_a(8'hAA); send_a(8'h12);
        repeat (5) @(negedge clk);
        check("a_strobe_count", n_strobe_a, 1);
        check("a_word_data", 32'(a_word), 32'h55AA12);
        check("a_strobe_addr", 32'(a_addr), 0);
        check("a_addr_after", 32'(word_addr_a), 1);
        check("a_frame_err", n_ferr_a, 0);
        check("a_busy_idle", 32'(busy_a), 0);

        // Table of back-to-back words; five words wrap the 2-bit address 0,1,2,3,0.
        din_en_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            last_word = '0;
            send_b(tbl[i].b0, 1, 0);
            send_b(tbl[i].b1, 1, 0);
            send_b(tbl[i].b2, 1, 0);
            if (i == 0) check("strobe_latency", last_strobe_cyc - t_fall, STROBE_LAT);
            check("tbl_word", 32'(last_word), 32'(tbl[i].exp));
            check("tbl_addr_after", 32'(word_addr_b), (i + 1) % 4);
        end
        repeat (4) @(negedge clk);
        check("busy_after_words", 32'(busy_b), 0);

        // Short glitch on the line: no frame, busy drops back.
        strobes0 = obs_strobes;
        rx_b = 1'b0;
        repeat (4) @(negedge clk);
        rx_b = 1'b1;
        check("glitch_busy_high", 32'(busy_b), 1);
        repeat (20) @(negedge clk);
        check("glitch_busy_low", 32'(busy_b), 0);
        check("glitch_no_strobe", obs_strobes, strobes0);
        check("glitch_no_ferr", obs_ferr, 0);

        // Framing error on the second byte, held low as a break, then a fresh word.
        addr0 = int'(word_addr_b);
        send_b(8'h11, 1, 0);
        send_b(8'h22, 0, 0);
        check("ferr_latency", last_ferr_cyc - t_fall, STROBE_LAT);
        check("ferr_count", obs_ferr, 1);
        check("ferr_busy_low", 32'(busy_b), 0);
        send_b(8'h01, 1, 0); send_b(8'h02, 1, 0); send_b(8'h03, 1, 1);
        check("after_ferr_word", 32'(last_word), 32'h010203);
        check("after_ferr_addr", 32'(word_addr_b), (addr0 + 1) % 4);

        // Storage disabled, then a partial word abandoned by a disabled byte.
        strobes0 = obs_strobes;
        addr0    = int'(word_addr_b);
        din_en_b = 1'b1;
        send_b(8'hA1, 1, 0); send_b(8'hA2, 1, 0); send_b(8'hA3, 1, 1);
        check("disabled_no_strobe", obs_strobes, strobes0);
        check("disabled_addr", 32'(word_addr_b), addr0);
        din_en_b = 1'b0; send_b(8'hB1, 1, 0);
        din_en_b = 1'b1; send_b(8'hB2, 1, 0);
        din_en_b = 1'b0;
        send_b(8'hC1, 1, 0); send_b(8'hC2, 1, 0); send_b(8'hC3, 1, 1);
        check("reenable_word", 32'(last_word), 32'hC1C2C3);
        check("reenable_one_strobe", obs_strobes, strobes0 + 1);

        // Randomized frames against the model.
        for (int i = 0; i < 24; i++) begin
            din_en_b = ($urandom_range(3) == 0);
            send_b(8'($urandom_range(255)), $urandom_range(7) != 0, $urandom_range(2));
        end
        din_en_b = 1'b0;
        repeat (2*CPB) @(negedge clk);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_ferr_count", obs_ferr, exp_ferr);

        // Make sure the address is nonzero, then reset in the middle of data bit 4.
        send_b(8'h12, 1, 0); send_b(8'h34, 1, 0); send_b(8'h56, 1, 1);
        if (word_addr_b == 2'd0) begin
            send_b(8'h12, 1, 0); send_b(8'h34, 1, 0); send_b(8'h56, 1, 1);
        end
        check("pre_reset_addr_nonzero", 32'(word_addr_b != 2'd0), 1);
        rx_b = 1'b0;
        repeat (5*CPB + CPB/2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_word_data", 32'(word_data_b), 0);
        check("midrst_word_addr", 32'(word_addr_b), 0);
        check("midrst_busy", 32'(busy_b), 0);
        check("midrst_frame_err", 32'(frame_err_b), 0);
        check("midrst_word_valid", 32'(word_valid_b), 0);
        exp_q.delete();
        m_idx  = 0;
        m_addr = 0;
        rx_b   = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        strobes0 = obs_strobes;
        send_b(8'hA5, 1, 0); send_b(8'h5A, 1, 0); send_b(8'hC3, 1, 1);
        check("post_reset_word", 32'(last_word), 32'hA55AC3);
        check("post_reset_strobes", obs_strobes, strobes0 + 1);
        check("post_reset_addr", 32'(word_addr_b), 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
